// File: rtl/width_arb_pkg.sv
// Shared types and widths for the two-source 8-to-16 byte-pair arbiter.
package width_arb_pkg;
    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;
    localparam int SRC_W  = 1;

    typedef enum logic {
        IDLE = 1'b0,
        HALF = 1'b1
    } st_e;
endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick: a lone valid source wins,
// otherwise ptr breaks the tie.
module rr_arb2 (
    input  logic valid0,
    input  logic valid1,
    input  logic ptr,
    output logic sel,
    output logic any_valid
);
    always_comb begin
        sel = valid1;
        if (valid0 && valid1) begin
            sel = ptr;
        end
        any_valid = valid0 | valid1;
    end
endmodule

// File: rtl/width_8to16_arb.sv
// Two-source arbiter/sequencer packing byte pairs from one source into a tagged
// 16-bit word. Optional mid-pair abandon timer is enabled by macro ARB_TIMEOUT_EN.
//
//   state | meaning
//   IDLE  | no grant held; next valid source (round-robin) supplies the high byte
//   HALF  | grant locked to gnt_q; waiting for the low byte from that source
module width_8to16_arb
    import width_arb_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [BYTE_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [BYTE_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              valid_out,
    output logic [WORD_W-1:0] data_out,
    output logic [SRC_W-1:0]  src_out,
    output logic              drop_out
);
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

    st_e               st_q, st_d;
    logic              ptr_q, ptr_d;
    logic              gnt_q, gnt_d;
    logic [BYTE_W-1:0] hi_q, hi_d;
    logic              valid_out_q, valid_out_d;
    logic [WORD_W-1:0] data_out_q, data_out_d;
    logic              src_out_q, src_out_d;

    logic              arb_sel, arb_any;
    logic              gnt_valid;
    logic [BYTE_W-1:0] gnt_data, sel_data;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              drop_out_q, drop_out_d;
`endif

    rr_arb2 u_rr_arb2 (
        .valid0    (req0_valid),
        .valid1    (req1_valid),
        .ptr       (ptr_q),
        .sel       (arb_sel),
        .any_valid (arb_any)
    );

    assign gnt_valid = gnt_q ? req1_valid : req0_valid;
    assign gnt_data  = gnt_q ? req1_data  : req0_data;
    assign sel_data  = arb_sel ? req1_data : req0_data;

    always_comb begin
        st_d        = st_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        hi_d        = hi_q;
        valid_out_d = 1'b0;
        data_out_d  = data_out_q;
        src_out_d   = src_out_q;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
`ifdef ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        drop_out_d  = 1'b0;
`endif
        // Readies stay low while reset is asserted, whatever the current state.
        if (!rst) begin
            case (st_q)
                IDLE: begin
                    if (arb_any) begin
                        req0_ready = ~arb_sel;
                        req1_ready = arb_sel;
                        hi_d       = sel_data;
                        gnt_d      = arb_sel;
                        st_d       = HALF;
`ifdef ARB_TIMEOUT_EN
                        cnt_d      = '0;
`endif
                    end
                end
                HALF: begin
                    req0_ready = ~gnt_q;
                    req1_ready = gnt_q;
                    if (gnt_valid) begin
                        data_out_d  = {hi_q, gnt_data};
                        src_out_d   = gnt_q;
                        valid_out_d = 1'b1;
                        ptr_d       = ~gnt_q;
                        st_d        = IDLE;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (cnt_q == CNT_W'(TIMEOUT)) begin
                        hi_d       = '0;
                        src_out_d  = gnt_q;
                        drop_out_d = 1'b1;
                        ptr_d      = ~gnt_q;
                        st_d       = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`endif
                end
                default: st_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q        <= IDLE;
            ptr_q       <= 1'b0;
            gnt_q       <= 1'b0;
            hi_q        <= '0;
            valid_out_q <= 1'b0;
            data_out_q  <= '0;
            src_out_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt_q       <= '0;
            drop_out_q  <= 1'b0;
`endif
        end else begin
            st_q        <= st_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            hi_q        <= hi_d;
            valid_out_q <= valid_out_d;
            data_out_q  <= data_out_d;
            src_out_q   <= src_out_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
            drop_out_q  <= drop_out_d;
`endif
        end
    end

    assign valid_out = valid_out_q;
    assign data_out  = data_out_q;
    assign src_out   = src_out_q;
`ifdef ARB_TIMEOUT_EN
    assign drop_out  = drop_out_q;
`else
    assign drop_out  = 1'b0;
`endif
endmodule

// File: doc/width_8to16_arb.md
# width_8to16_arb

Two-source arbiter and sequencer for the 8-to-16 byte-pair packing datapath. Two independent byte producers share one packer. Grant is round-robin and locked per pair, so the high and low bytes of every 16-bit word always come from the same source. The packed word carries a source tag and feeds the downstream 16-bit consumer.

## Interface
Parameters:
- TIMEOUT, 15, number of consecutive stalled cycles allowed mid-pair before abandon. Legal range ≥1. Used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req0_valid  in  1  source 0 byte valid.
- req0_data  in  8  source 0 byte.
- req0_ready  out  1  source 0 byte accepted this cycle. Combinational.
- req1_valid  in  1  source 1 byte valid.
- req1_data  in  8  source 1 byte.
- req1_ready  out  1  source 1 byte accepted this cycle. Combinational.
- valid_out  out  1  one-cycle pulse: data_out/src_out hold a new word.
- data_out  out  16  packed word, {first byte, second byte}.
- src_out  out  1  source index of the word (or of the drop).
- drop_out  out  1  one-cycle pulse: a half-word was abandoned. Tied 0 without ARB_TIMEOUT_EN.

## Operation
- A byte transfers when reqN_valid && reqN_ready. Sources must hold valid and data until accepted.
- Round-robin pointer ptr (1 bit) marks the preferred source. Reset value is 0.
- State IDLE (no grant held):
  - Selection: if exactly one source is valid, that source is selected. If both are valid, ptr is selected.
  - The selected source's ready is 1. Its byte is stored in hi_byte, gnt takes the selected index, and the state moves to HALF.
  - With no valid source, both readies are 0 and the block stays in IDLE.
- State HALF (grant locked to gnt):
  - Only reqgnt_ready is 1. The other source is stalled regardless of its valid.
  - On a transfer: data_out gets {hi_byte, byte}, src_out gets gnt, valid_out pulses, ptr gets ~gnt, and the state returns to IDLE.
- The next pair cannot start in the cycle a word completes, so peak throughput is one word per 2 cycles.
- data_out and src_out hold their last value between words. hi_byte is not visible externally.

## Timing
- Reset values: state IDLE, ptr 0, gnt 0, hi_byte 0, stall counter 0, valid_out 0, data_out 16'h0000, src_out 0, drop_out 0. Readies are 0 during the reset cycle.
- Latency: valid_out is high in the cycle after the second-byte handshake, i.e. registered.
- Both sources are valid continuously from IDLE with ptr=0. Accepted byte order is s0, s0, s1, s1, s0, … Words emerge at cycles 2, 4, 6, …
- Reset asserted in HALF: the held byte is discarded with no valid_out and no drop_out. Arbitration restarts with ptr=0.
- valid_out and drop_out are never high in the same cycle.

## Configuration
- Macro ARB_TIMEOUT_EN.
- Defined:
  - In HALF, a counter of width $clog2(TIMEOUT+1) increments on each cycle where the granted source is not valid. It clears on entry to HALF.
  - When the counter reaches TIMEOUT, the next edge does the following: drop hi_byte, pulse drop_out with src_out = gnt, set ptr to ~gnt, and return to IDLE.
  - If the granted byte arrives in the same cycle the counter reaches TIMEOUT, completion wins and no drop occurs.
- Undefined: no counter exists and drop_out is constant 0. HALF waits indefinitely.

## Structure
- Package width_arb_pkg holds:
  - state enum typedef st_e {IDLE, HALF};
  - localparams BYTE_W=8, WORD_W=16, SRC_W=1.
- One sub-module, rr_arb2: a combinational 2-way round-robin pick. Inputs are two valids and ptr; outputs are a select index and an any_valid flag.
- The FSM, hi_byte, pack register and timeout counter stay in the top.

## Test plan
- Single source: source 0 sends 8'hAB then 8'hCD. Expect valid_out one cycle after the second accept, data_out=16'hABCD, src_out=0.
- Contention: both sources are valid continuously; s0 sends 11,22,33,44 and s1 sends AA,BB,CC,DD. Expect words 1122(s0), AABB(s1), 3344(s0), CCDD(s1). req1_ready is 0 while s0 holds the grant.
- Mid-pair stall: s0 sends 8'h5A, then drops valid for 3 cycles while s1 is valid. s1 must stay unaccepted. s0 then sends 8'hA5. Expect 16'h5AA5, src 0, and the next grant goes to s1.
- Reset mid-pair: s0 sends 8'h77, then rst is asserted for 1 cycle. Expect no valid_out and all outputs at reset values. Then s1 sends 01,02. Expect 16'h0102, src 1.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT=4): s0 sends one byte and then goes silent. Expect a drop_out pulse with src_out=0 after exactly 4 stall cycles, followed by a grant to s1. A second run delivers the byte on the 4th stall cycle and expects a normal word with no drop.
